// File: rtl/input_window_fetcher_pkg.sv
// Shared types for the input-router address path: FSM state encoding and
// the default window-index width.
package input_router_pkg;

  localparam int unsigned ADDR_LENGTH_DEF = 9;
  localparam int unsigned IDX_W           = $clog2(ADDR_LENGTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/input_window_fetcher_tag_pipe.sv
// Read-tag delay line: carries {valid,pad,idx} alongside each SRAM read so
// the returned data lands in the right window slot LAT cycles later.
module read_tag_pipe
  import input_router_pkg::*;
#(
  parameter int unsigned LAT = 1,
  parameter int unsigned IW  = IDX_W
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pad,
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic          o_pad,
  output logic [IW-1:0] o_idx
);

  logic [LAT-1:0]         v_q;
  logic [LAT-1:0]         pad_q;
  logic [LAT-1:0][IW-1:0] idx_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      v_q   <= '0;
      pad_q <= '0;
      idx_q <= '0;
    end else if (i_clear) begin
      v_q   <= '0;
      pad_q <= '0;
      idx_q <= '0;
    end else begin
      v_q[0]   <= i_push;
      pad_q[0] <= i_pad;
      idx_q[0] <= i_idx;
      for (int unsigned i = 1; i < LAT; i++) begin
        v_q[i]   <= v_q[i-1];
        pad_q[i] <= pad_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign o_valid = v_q[LAT-1];
  assign o_pad   = pad_q[LAT-1];
  assign o_idx   = idx_q[LAT-1];

endmodule

// File: rtl/input_window_fetcher.sv
// Window fetcher: one SRAM read per cycle, assembles ADDR_LENGTH activations
// and hands the window to a PE row. Optional INPUT_ROUTER_ZERO_PAD_EN zero-pads slots.
module input_window_fetcher
  import input_router_pkg::*;
#(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned ADDR_LENGTH = 9,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_reg_clear,
  input  logic                                   i_valid,
  input  logic [ADDR_LENGTH-1:0][ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0]                  i_o_x,
  input  logic [ADDR_WIDTH-1:0]                  i_o_y,
  input  logic [ROWS-1:0]                        i_row_id,
`ifdef INPUT_ROUTER_ZERO_PAD_EN
  input  logic [ADDR_WIDTH-1:0]                  i_addr_limit,
`endif
  output logic                                   o_ready,
  output logic                                   o_rd_en,
  output logic [ADDR_WIDTH-1:0]                  o_rd_addr,
  input  logic [DATA_WIDTH-1:0]                  i_rd_data,
  output logic                                   o_valid,
  output logic [ADDR_LENGTH-1:0][DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0]                  o_o_x,
  output logic [ADDR_WIDTH-1:0]                  o_o_y,
  output logic [ROWS-1:0]                        o_row_id,
  input  logic                                   i_ready,
  output logic                                   o_overrun
);

  localparam int unsigned IW = (ADDR_LENGTH > 1) ? $clog2(ADDR_LENGTH) : 1;
  localparam int unsigned CW = $clog2(ADDR_LENGTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(ADDR_LENGTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(ADDR_LENGTH);

  state_t state_q, state_d;

  logic [ADDR_LENGTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_LENGTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0]                  ox_q, oy_q;
  logic [ROWS-1:0]                        row_q;
  logic [IW-1:0]                          idx_q, idx_d;
  logic [CW-1:0]                          rcv_q, rcv_d;
  logic                                   overrun_q;

  logic          accept, fetching, pad_slot;
  logic          tag_v, tag_pad;
  logic [IW-1:0] tag_idx;

  assign accept   = i_valid && (state_q == IDLE);
  assign fetching = (state_q == FETCH);

`ifdef INPUT_ROUTER_ZERO_PAD_EN
  assign pad_slot = (addr_q[idx_q] >= i_addr_limit);
`else
  assign pad_slot = 1'b0;
`endif

  read_tag_pipe #(
    .LAT (RD_LATENCY),
    .IW  (IW)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_clear (i_reg_clear),
    .i_push  (fetching),
    .i_pad   (pad_slot),
    .i_idx   (idx_q),
    .o_valid (tag_v),
    .o_pad   (tag_pad),
    .o_idx   (tag_idx)
  );

  // Count includes the tag retiring this cycle so OUT is entered on the
  // same edge that stores the last word.
  always_comb begin
    rcv_d = rcv_q + (tag_v ? CW'(1) : CW'(0));
    idx_d = idx_q;
    if (accept) begin
      idx_d = '0;
    end else if (fetching && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_reg_clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (i_valid) state_d = FETCH;
        FETCH: if (idx_q == LAST_IDX) state_d = DRAIN;
        DRAIN: if (rcv_d == FULL_CNT) state_d = OUT;
        OUT:   if (i_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready   = (state_q == IDLE);
    o_rd_en   = fetching && !pad_slot;
    o_rd_addr = fetching ? addr_q[idx_q] : '0;
    o_valid   = (state_q == OUT);
    o_data    = o_valid ? data_q : '0;
    o_o_x     = o_valid ? ox_q   : '0;
    o_o_y     = o_valid ? oy_q   : '0;
    o_row_id  = o_valid ? row_q  : '0;
    o_overrun = overrun_q;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      addr_q    <= '0;
      data_q    <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      rcv_q     <= '0;
      overrun_q <= 1'b0;
    end else if (i_reg_clear) begin
      addr_q    <= '0;
      data_q    <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      rcv_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      if (accept) begin
        addr_q <= i_addr;
        ox_q   <= i_o_x;
        oy_q   <= i_o_y;
        row_q  <= i_row_id;
        rcv_q  <= '0;
      end else begin
        rcv_q <= rcv_d;
      end
      if (i_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (tag_v) begin
        data_q[tag_idx] <= tag_pad ? '0 : i_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_input_window_fetcher.sv
// Directed bench for input_window_fetcher: two instances (read latency 1 and 3)
// share stimulus, each backed by its own SRAM model with mem[a] = a + 16.
module tb_input_window_fetcher;

  localparam int unsigned ROWS = 4;
  localparam int unsigned AW   = 6;
  localparam int unsigned AL   = 9;
  localparam int unsigned DW   = 8;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic                   i_clk = 1'b0;
  logic                   i_nrst, i_reg_clear, i_valid, i_ready;
  logic [AL-1:0][AW-1:0]  i_addr;
  logic [AW-1:0]          i_o_x, i_o_y;
  logic [ROWS-1:0]        i_row_id;
`ifdef INPUT_ROUTER_ZERO_PAD_EN
  logic [AW-1:0]          i_addr_limit;
`endif

  logic                   o_ready1, o_rd_en1, o_valid1, o_overrun1;
  logic [AW-1:0]          o_rd_addr1, o_o_x1, o_o_y1;
  logic [DW-1:0]          rd_data1;
  logic [AL-1:0][DW-1:0]  o_data1;
  logic [ROWS-1:0]        o_row_id1;

  logic                   o_ready3, o_rd_en3, o_valid3, o_overrun3;
  logic [AW-1:0]          o_rd_addr3, o_o_x3, o_o_y3;
  logic [DW-1:0]          rd_data3, p0, p1, p2;
  logic [AL-1:0][DW-1:0]  o_data3;
  logic [ROWS-1:0]        o_row_id3;

  logic [AL-1:0][DW-1:0]  exp_data;

  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {2'b00, a} + 8'd16;
  endfunction

  always @(posedge i_clk) rd_data1 <= o_rd_en1 ? mem(o_rd_addr1) : 8'hEE;

  always @(posedge i_clk) begin
    p0 <= o_rd_en3 ? mem(o_rd_addr3) : 8'hEE;
    p1 <= p0;
    p2 <= p1;
  end
  assign rd_data3 = p2;

  input_window_fetcher #(
    .ROWS(ROWS), .ADDR_WIDTH(AW), .ADDR_LENGTH(AL), .DATA_WIDTH(DW), .RD_LATENCY(1)
  ) dut1 (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_valid(i_valid),
    .i_addr(i_addr), .i_o_x(i_o_x), .i_o_y(i_o_y), .i_row_id(i_row_id),
`ifdef INPUT_ROUTER_ZERO_PAD_EN
    .i_addr_limit(i_addr_limit),
`endif
    .o_ready(o_ready1), .o_rd_en(o_rd_en1), .o_rd_addr(o_rd_addr1), .i_rd_data(rd_data1),
    .o_valid(o_valid1), .o_data(o_data1), .o_o_x(o_o_x1), .o_o_y(o_o_y1),
    .o_row_id(o_row_id1), .i_ready(i_ready), .o_overrun(o_overrun1)
  );

  input_window_fetcher #(
    .ROWS(ROWS), .ADDR_WIDTH(AW), .ADDR_LENGTH(AL), .DATA_WIDTH(DW), .RD_LATENCY(3)
  ) dut3 (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_valid(i_valid),
    .i_addr(i_addr), .i_o_x(i_o_x), .i_o_y(i_o_y), .i_row_id(i_row_id),
`ifdef INPUT_ROUTER_ZERO_PAD_EN
    .i_addr_limit(i_addr_limit),
`endif
    .o_ready(o_ready3), .o_rd_en(o_rd_en3), .o_rd_addr(o_rd_addr3), .i_rd_data(rd_data3),
    .o_valid(o_valid3), .o_data(o_data3), .o_o_x(o_o_x3), .o_o_y(o_o_y3),
    .o_row_id(o_row_id3), .i_ready(i_ready), .o_overrun(o_overrun3)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int fv1, fv3, n9, nrd3;

    i_nrst = 1'b0; i_reg_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_addr = '0; i_o_x = '0; i_o_y = '0; i_row_id = '0;
`ifdef INPUT_ROUTER_ZERO_PAD_EN
    i_addr_limit = 6'd63;
`endif
    repeat (3) tick();
    chk("rst_ready_in_reset", o_ready1, 1'b1);
    i_nrst = 1'b1;
    tick();
    chk("rst_ready", o_ready1, 1'b1);
    chk("rst_valid", o_valid1, 1'b0);
    chk("rst_rd_en", o_rd_en1, 1'b0);
    chk("rst_rd_addr", o_rd_addr1, 6'd0);
    chk("rst_overrun", o_overrun1, 1'b0);
    chk("rst_data", o_data1, 72'd0);
    chk("rst_row_id", o_row_id1, 4'd0);

    // Test 1+2: addr 0..8, window held 5+ cycles in OUT by i_ready=0
    for (int i = 0; i < AL; i++) begin
      i_addr[i] = AW'(i);
      exp_data[i] = DW'(16 + i);
    end
    i_o_x = 6'd5; i_o_y = 6'd9; i_row_id = 4'b0100; i_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) i_valid = 1'b0;
      if (k == 3) i_ready = 1'b1;
      if (k == 4) i_ready = 1'b0;
      chk("t1_rd_en", o_rd_en1, (k <= 9));
      if (k <= 9) chk("t1_rd_addr", o_rd_addr1, AW'(k - 1));
      chk("t1_valid", o_valid1, (k >= 11));
      chk("t1_ready_busy", o_ready1, 1'b0);
      if (k >= 11) begin
        chk("t1_data", o_data1, exp_data);
        chk("t1_o_x", o_o_x1, 6'd5);
        chk("t1_o_y", o_o_y1, 6'd9);
        chk("t1_row_id", o_row_id1, 4'b0100);
      end
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("t2_ready_after_hs", o_ready1, 1'b1);
    chk("t2_valid_after_hs", o_valid1, 1'b0);
    chk("t2_ready3_after_hs", o_ready3, 1'b1);

    // Test 3: overrun from a descriptor during FETCH, cleared by i_reg_clear
    for (int i = 0; i < AL; i++) begin
      i_addr[i] = AW'(8 - i);
      exp_data[i] = DW'(24 - i);
    end
    i_o_x = 6'd1; i_o_y = 6'd2; i_row_id = 4'b0001; i_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) i_valid = 1'b0;
      if (k == 3) begin
        i_valid = 1'b1;
        i_addr = '1;
        i_row_id = 4'b1000;
      end
      if (k == 4) begin
        i_valid = 1'b0;
        chk("t3_overrun_set", o_overrun1, 1'b1);
      end
      if (k == 11) begin
        chk("t3_valid", o_valid1, 1'b1);
        chk("t3_data", o_data1, exp_data);
        chk("t3_row_id", o_row_id1, 4'b0001);
        i_ready = 1'b1;
      end
      if (k == 12) begin
        chk("t3_ready", o_ready1, 1'b1);
        chk("t3_overrun_sticky", o_overrun1, 1'b1);
      end
    end
    i_ready = 1'b0;
    i_reg_clear = 1'b1;
    tick();
    i_reg_clear = 1'b0;
    chk("t3_overrun_cleared", o_overrun1, 1'b0);

    // Test 4: clear in FETCH cycle 5, then a clean window
    for (int i = 0; i < AL; i++) i_addr[i] = AW'(2 * i);
    i_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) i_valid = 1'b0;
      if (k == 5) i_reg_clear = 1'b1;
      if (k == 6) begin
        i_reg_clear = 1'b0;
        chk("t4_rd_en_stop", o_rd_en1, 1'b0);
        chk("t4_ready", o_ready1, 1'b1);
      end
      if (k >= 6) chk("t4_no_valid", o_valid1 | o_valid3, 1'b0);
    end
    for (int i = 0; i < AL; i++) begin
      i_addr[i] = AW'(i + 3);
      exp_data[i] = DW'(19 + i);
    end
    i_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) i_valid = 1'b0;
      if (k == 11) begin
        chk("t4_valid_next", o_valid1, 1'b1);
        chk("t4_data_next", o_data1, exp_data);
        i_ready = 1'b1;
      end
      if (k == 13) begin
        chk("t4_valid3_next", o_valid3, 1'b1);
        chk("t4_data3_next", o_data3, exp_data);
      end
    end
    i_ready = 1'b0;

    // Test 5: duplicate addresses, latency 1 vs 3
    for (int i = 0; i < AL; i++) begin
      i_addr[i] = (i < 2) ? 6'd9 : AW'(i - 2);
      exp_data[i] = (i < 2) ? 8'd25 : DW'(16 + i - 2);
    end
    fv1 = 0; fv3 = 0; n9 = 0; nrd3 = 0;
    i_valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) i_valid = 1'b0;
      if (o_valid1 && fv1 == 0) fv1 = k;
      if (o_valid3 && fv3 == 0) fv3 = k;
      if (o_rd_en1 && o_rd_addr1 == 6'd9) n9++;
      if (o_rd_en3) nrd3++;
      if (k == 14) begin
        chk("t5_data1", o_data1, exp_data);
        chk("t5_data3", o_data3, exp_data);
        i_ready = 1'b1;
      end
      if (k == 15) chk("t5_ready3", o_ready3, 1'b1);
    end
    i_ready = 1'b0;
    chk("t5_dup_reads", n9, 2);
    chk("t5_reads3", nrd3, 9);
    chk("t5_valid_cycle1", fv1, 11);
    chk("t5_valid_cycle3", fv3, 13);

`ifdef INPUT_ROUTER_ZERO_PAD_EN
    // Test 6: slots at or above the limit are padded with zero
    i_addr_limit = 6'd4;
    for (int i = 0; i < AL; i++) begin
      i_addr[i] = AW'(i);
      exp_data[i] = (i < 4) ? DW'(16 + i) : 8'd0;
    end
    fv1 = 0;
    i_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) i_valid = 1'b0;
      chk("t6_rd_en", o_rd_en1, (k <= 4));
      if (o_valid1 && fv1 == 0) fv1 = k;
      if (k == 11) begin
        chk("t6_data", o_data1, exp_data);
        i_ready = 1'b1;
      end
    end
    i_ready = 1'b0;
    chk("t6_valid_cycle", fv1, 11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
